cmp_arbiter: RTL and testbench
==============================

Name: cmp_arbiter

Overview:
Shares one combinational magnitude-comparator core between N_REQ requesters, granting access round-robin. Each requester presents an operand pair and holds a request. The block grants one requester, latches that requester's operands and returns registered L/G/E flags with a one-cycle ack. It sits between several compare clients (sorters, threshold checkers) and a single comparator instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 2, operand width in bits
IDW, $clog2(N_REQ), grant index width (derived, not user-set)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester level request; bit i = requester i
a_bus  in  N_REQ*WIDTH  operand A; slice [i*WIDTH +: WIDTH] belongs to requester i
b_bus  in  N_REQ*WIDTH  operand B; same slicing as a_bus
ack  out  N_REQ  one-hot, one-cycle pulse; result valid for requester i
grant_id  out  IDW  index of the requester currently being served
L  out  1  registered result: A < B
G  out  1  registered result: A > B
E  out  1  registered result: A == B
busy  out  1  high in GRANT and RESP states

Behaviour:
- Single clock domain.
- reset_n is asynchronous and active-low. While reset_n is low: state=IDLE, ack=0, grant_id=0, L=G=E=0, busy=0, round-robin pointer last=N_REQ-1, operand latches=0.
- FSM has three states: IDLE, GRANT, RESP.
- IDLE:
  - If req!=0, pick the first set bit searching from (last+1) mod N_REQ upward with wrap-around.
  - Register that index into grant_id and last.
  - Latch its A and B slices into internal op_a and op_b, then go to GRANT.
  - If req==0, stay in IDLE.
- GRANT (1 cycle):
  - The comparator core evaluates op_a and op_b.
  - L/G/E are registered at the end of this cycle. Exactly one of L, G, E is set, unsigned compare.
  - Go to RESP.
- RESP (1 cycle):
  - ack[grant_id]=1, all other ack bits 0.
  - L/G/E stay valid and hold their value until the next GRANT completes.
  - Go to IDLE.
- Latency: req sampled high in IDLE at edge t, so ack is high during cycle t+2. Maximum throughput is one compare per 3 cycles.
- Handshake:
  - A requester holds req until it sees ack, then must drop req in the cycle after ack if it has no further request.
  - If req stays high after ack, it is a new request and is arbitrated normally. Round-robin still gives the other requesters priority first.
- Operands are latched at grant. Changing a_bus/b_bus or dropping req during GRANT/RESP does not affect the in-flight result; ack is still issued.
- Fairness: with all req bits high, grants cycle 0,1,2,...,N_REQ-1,0,... No requester waits more than N_REQ grants.
- Requests that arrive while busy are ignored until the next IDLE.
- Reset mid-operation: the transaction is aborted and no ack is issued. After release, the first grant searches from index 0.
- Out-of-range requesters: when N_REQ is not a power of two, grant_id never exceeds N_REQ-1.

Decomposition:
- Shared header/package holds:
  - FSM state encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_RESP=2'd2 (2'd3 unreachable; decodes to IDLE).
  - The result-flag ordering {L,G,E} for reuse by client blocks.
- One sub-module: mag_cmp_core. It is a combinational, WIDTH-parameterised unsigned comparator with outputs lt/gt/eq, exactly one set.
- The round-robin search stays inline in cmp_arbiter as a function.

Test Plan:
1. Reset sequence: hold reset_n=0 for 3 cycles with req=4'b1111 → ack=0, L=G=E=0, busy=0. Release → first grant_id=0, ack=4'b0001 two cycles later.
2. Single requester: req=4'b0100, A2=2'd1, B2=2'd3 → grant_id=2, then ack=4'b0100 at t+2 with L=1, G=0, E=0. Repeat with A2=3, B2=0 → G=1. Repeat with A2=B2=2 → E=1.
3. All requesting: req=4'b1111 held for 12 cycles → ack pulses in order 0001, 0010, 0100, 1000, one every 3 cycles, with correct flags per slice.
4. Operand change in flight: grant requester 1 with A=3, B=1, then set A=0 in the GRANT cycle → result is still G=1, with ack[1] pulsed.
5. Reset in GRANT: assert reset_n=0 during GRANT → no ack pulse and outputs go to 0 asynchronously within the same cycle. After release with req=4'b1000 → grant_id=3.
6. Wrap-around: last=3 and req=4'b1001 → grant_id=0 next, then 3, alternating.

Source files
------------

// File: rtl/cmp_arbiter_pkg.sv
// Shared definitions for the round-robin comparator arbiter and its clients.
package cmp_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  // Bit positions of the result flags when packed as {L,G,E}.
  localparam int unsigned FLAG_L = 2;
  localparam int unsigned FLAG_G = 1;
  localparam int unsigned FLAG_E = 0;

  typedef struct packed {
    logic l;
    logic g;
    logic e;
  } cmp_flags_t;

endpackage

// File: rtl/mag_cmp_core.sv
// Combinational unsigned magnitude comparator; exactly one of lt/gt/eq is set.
module mag_cmp_core #(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  always_comb begin
    lt = (a < b);
    gt = (a > b);
    eq = (a == b);
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one magnitude comparator among N_REQ requesters.
module cmp_arbiter
  import cmp_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  parameter  int unsigned WIDTH = 2,
  localparam int unsigned IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_bus,
  input  logic [N_REQ*WIDTH-1:0] b_bus,
  output logic [N_REQ-1:0]       ack,
  output logic [IDW-1:0]         grant_id,
  output logic                   L,
  output logic                   G,
  output logic                   E,
  output logic                   busy
);

  state_t           state, state_n;
  logic [IDW-1:0]   last;
  logic [IDW-1:0]   pick;
  logic [WIDTH-1:0] op_a, op_b;
  cmp_flags_t       flags;
  logic             core_lt, core_gt, core_eq;
  logic             load_grant, load_flags;

  // First set bit strictly after 'from', wrapping; indices stay below N_REQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IDW-1:0]   from);
    logic [IDW-1:0] sel;
    logic           found;
    int unsigned    idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(from) + k) % N_REQ;
      if (!found && r[idx]) begin
        sel   = IDW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb pick = rr_pick(req, last);

  mag_cmp_core #(.WIDTH(WIDTH)) u_core (
    .a  (op_a),
    .b  (op_b),
    .lt (core_lt),
    .gt (core_gt),
    .eq (core_eq)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n    = state;
    load_grant = 1'b0;
    load_flags = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          load_grant = 1'b1;
          state_n    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        load_flags = 1'b1;
        state_n    = ST_RESP;
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_id <= '0;
      last     <= IDW'(N_REQ - 1);
      op_a     <= '0;
      op_b     <= '0;
      flags    <= '0;
    end else begin
      if (load_grant) begin
        grant_id <= pick;
        last     <= pick;
        op_a     <= a_bus[pick*WIDTH +: WIDTH];
        op_b     <= b_bus[pick*WIDTH +: WIDTH];
      end
      if (load_flags) begin
        flags <= '{l: core_lt, g: core_gt, e: core_eq};
      end
    end
  end

  // ack and busy decode straight from the state register so reset clears them at once.
  always_comb begin
    ack  = (state == ST_RESP) ? (N_REQ'(1) << grant_id) : '0;
    busy = (state == ST_GRANT) || (state == ST_RESP);
    L    = flags.l;
    G    = flags.g;
    E    = flags.e;
  end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: expected results queued at grant, checked at ack.
module tb_cmp_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 2;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a_bus = '0;
  logic [N*W-1:0] b_bus = '0;
  logic [N-1:0]   ack;
  logic [1:0]     grant_id;
  logic           L, G, E, busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int           due;
    logic [N-1:0] ack;
    logic [1:0]   id;
    logic [2:0]   lge;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   phase = 0;
  int   m_last = N - 1;

  cmp_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .a_bus    (a_bus),
    .b_bus    (b_bus),
    .ack      (ack),
    .grant_id (grant_id),
    .L        (L),
    .G        (G),
    .E        (E),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] r, input int from);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (from + 1 + k) % N;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_bus[i*W +: W] = a;
    b_bus[i*W +: W] = b;
  endtask

  // Reference model: decides grants from the bench's own view of the inputs.
  initial forever begin
    exp_t        e;
    int          p;
    logic [W-1:0] a, b;
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      phase  = 0;
      m_last = N - 1;
      sb.delete();
    end else begin
      cyc++;
      if (phase == 0 && req != '0) begin
        p      = model_pick(req, m_last);
        m_last = p;
        a      = a_bus[p*W +: W];
        b      = b_bus[p*W +: W];
        e.due  = cyc + 1;
        e.ack  = N'(1) << p;
        e.id   = 2'(p);
        e.lge  = {a < b, a > b, a == b};
        sb.push_back(e);
        phase  = 2;
      end else if (phase > 0) begin
        phase--;
      end
    end
  end

  // Monitor on the falling edge, away from the DUT's active edge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check_eq("ack", 32'(ack), 32'(e.ack));
      check_eq("grant_id", 32'(grant_id), 32'(e.id));
      check_eq("lge", 32'({L, G, E}), 32'(e.lge));
    end else begin
      check_eq("ack_quiet", 32'(ack), 32'd0);
    end
    check_eq("busy", 32'(busy), 32'(phase != 0));
  end

  task automatic single(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    set_op(idx, a, b);
    req = N'(1) << idx;
    @(negedge clk);
    check_eq("single_grant", 32'(grant_id), 32'(idx));
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // Reset held with all requesters active
    req   = 4'b1111;
    a_bus = 8'b11_10_01_00;
    b_bus = 8'b00_01_10_11;
    repeat (3) @(negedge clk);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_lge", 32'({L, G, E}), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_grant_id", 32'(grant_id), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("first_grant", 32'(grant_id), 32'd0);
    req = '0;
    repeat (3) @(negedge clk);

    // Single requester: less, greater, equal
    single(2, 2'd1, 2'd3);
    single(2, 2'd3, 2'd0);
    single(2, 2'd2, 2'd2);

    // Park the pointer at 3, then all requesters with changing operands
    single(3, 2'd0, 2'd0);
    @(negedge clk);
    req = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      a_bus = (N*W)'($urandom);
      b_bus = (N*W)'($urandom);
      @(negedge clk);
    end
    req = '0;
    repeat (4) @(negedge clk);

    // Operands and request change during GRANT must not disturb the result
    set_op(1, 2'd3, 2'd1);
    req = 4'b0010;
    @(posedge clk);
    #1;
    a_bus[1*W +: W] = 2'd0;
    req = '0;
    repeat (4) @(negedge clk);

    // Reset asserted during GRANT aborts the transaction
    set_op(2, 2'd0, 2'd3);
    req = 4'b0100;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_ack", 32'(ack), 32'd0);
    check_eq("abort_lge", 32'({L, G, E}), 32'd0);
    check_eq("abort_grant_id", 32'(grant_id), 32'd0);
    req = 4'b1000;
    set_op(3, 2'd2, 2'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_grant", 32'(grant_id), 32'd3);
    req = '0;
    repeat (3) @(negedge clk);

    // Wrap-around between requesters 0 and 3
    set_op(0, 2'd1, 2'd2);
    set_op(3, 2'd3, 2'd3);
    req = 4'b1001;
    repeat (12) @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
